host_mailbox: RTL

- Memory-mapped responder on the core's data bus that the test program writes to.
- Carries the riscv-tests "tohost" completion protocol (pass/fail plus failing test number) and a byte console.
- Decouples the result from architectural register inspection: benches watch `done`/`pass` instead of pc/x3.
- Sits beside data memory in Core. Address decode upstream asserts `sel` for this block's 16-byte window.

---
 rtl/host_mailbox.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/host_mailbox.sv
// Memory-mapped test mailbox: tohost completion register, fromhost register, console byte FIFO.
// Optional HOST_MAILBOX_TIMEOUT_EN adds a watchdog that forces a failing completion.
module host_mailbox #(
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] FROMHOST_RESET = 32'h0
`ifdef HOST_MAILBOX_TIMEOUT_EN
    ,parameter int         TIMEOUT_CYCLES = 5000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    input  logic        fromhost_wr,
    input  logic [31:0] fromhost_data
`ifdef HOST_MAILBOX_TIMEOUT_EN
    ,output logic       timeout
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, DONE} state_t;
    state_t state;

    logic [31:0] tohost, fromhost;
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full, empty, accept, push, pop;
    logic        con_st, toh_st, frh_st;
    logic [31:0] toh_new, frh_new, rd_val;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (count == (AW+1)'(FIFO_DEPTH));

    assign con_st = we && (addr[3:2] == 2'd2);
    assign toh_st = we && (addr[3:2] == 2'd0);
    assign frh_st = we && (addr[3:2] == 2'd1);

    // Stall is decided from the pre-edge full flag, so a same-cycle pop cannot free the slot.
    assign ready  = sel && !(con_st && full);
    assign accept = sel && ready;
    assign push   = accept && con_st && wstrb[0];
    assign pop    = !empty && con_ready;

    assign con_valid = !empty;
    assign con_data  = empty ? 8'h0 : mem[rd_ptr[AW-1:0]];

    assign toh_new = merge(tohost, wdata, wstrb);
    assign frh_new = merge(fromhost, wdata, wstrb);

    always_comb begin
        rd_val = 32'h0;
        case (addr[3:2])
            2'd0: rd_val = tohost;
            2'd1: rd_val = fromhost;
            2'd2: rd_val = {23'b0, full, 8'(count)};
            2'd3: rd_val = {29'b0, full, pass, done};
        endcase
    end

    // FIFO storage has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= wdata[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= 32'h0;
            rvalid   <= 1'b0;
            tohost   <= 32'h0;
            fromhost <= FROMHOST_RESET;
        end else begin
            rvalid <= accept && !we;
            if (accept && !we) rdata <= rd_val;
            if (accept && toh_st) tohost <= toh_new;
            if (fromhost_wr)
                fromhost <= fromhost_data;
            else if (accept && frh_st)
                fromhost <= frh_new;
        end
    end

`ifdef HOST_MAILBOX_TIMEOUT_EN
    logic [31:0] tmr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 31'h0;
`ifdef HOST_MAILBOX_TIMEOUT_EN
            timeout   <= 1'b0;
            tmr       <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && toh_st && toh_new[0]) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        pass      <= (toh_new[31:1] == 31'h0);
                        fail_code <= toh_new[31:1];
                    end
`ifdef HOST_MAILBOX_TIMEOUT_EN
                    else if (tmr == 32'(TIMEOUT_CYCLES - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_code <= 31'h7FFFFFFF;
                        timeout   <= 1'b1;
                    end else begin
                        tmr <= tmr + 32'h1;
                    end
`endif
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
